display_arbiter: RTL
====================

# display_arbiter

Shares the 4-digit hex display between four requesters (e.g. switch readout, counter, UART byte monitor, error code). It sits directly upstream of the display driver and supplies its value and dot inputs. Arbitration is round-robin with a minimum hold time, so each shown value stays readable for a guaranteed interval.

## Interface
- `HOLD_CYCLES`, default 24'd10_000_000: minimum cycles an owner keeps the display (100 ms at 100 MHz); a value of 0 is treated as 1.
- `IDLE_VAL`, default 16'h0000: value shown when no requester owns the display.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  4: request lines, one per requester; level-sensitive.
- `val0`..`val3`  in  16 each: hex value of requester k.
- `dot0`..`dot3`  in  4 each: decimal-point pattern of requester k.
- `grant`  out  4: one-hot grant, or 0 when idle; registered.
- `owner`  out  2: index of the current or last owner; registered.
- `busy`  out  1: high while any grant is asserted.
- `disp_val`  out  16: value for the display driver; registered.
- `disp_dot`  out  4: dot pattern for the display driver; registered.

## Operation
- **States:**
  - IDLE: `grant`=0.
  - OWN: exactly one grant bit is set.
- **Round-robin pointer `last`:**
  - Search order starts at `last`+1 mod 4.
  - `last` updates to the new owner on every grant.
- **IDLE → OWN:** when any `req` bit is high, grant the first requester in search order.
- **OWN, hold counter `hcnt` (24-bit):**
  - `hcnt` clears on every new grant and increments each cycle.
  - `hcnt` saturates at `HOLD_CYCLES`-1, which is the expired state.
- **OWN, owner drops `req`:** release immediately, regardless of `hcnt`.
  - If another `req` is high: switch directly to it, with no idle cycle.
  - Otherwise: go to IDLE.
- **OWN, hold expired and owner still requesting:**
  - If another `req` is high: switch to the next requester in search order and clear `hcnt`.
  - Otherwise: keep the grant, with `hcnt` held saturated.
- **No preemption:** other requests are ignored until the hold expires or the owner drops `req`.
- **Display data:**
  - While in OWN, `disp_val`/`disp_dot` load `val`/`dot` of the owner-to-be each cycle, so live updates from the owner track with 1-cycle latency.
  - In IDLE they load `IDLE_VAL` and 4'b0000.
- **Simultaneous owner drop and hold expiry:** treated as a drop; the result is the same arbitration.
- **Request with a one-cycle pulse from IDLE:** the grant still issues. On the next cycle `req` is low, so the block releases after one cycle of ownership.

## Timing
- **Reset values (asynchronous, effective immediately):**
  - `grant`=0, `owner`=0, `busy`=0
  - `disp_val`=`IDLE_VAL`, `disp_dot`=0
  - `last`=3 (first priority goes to requester 0), `hcnt`=0, state IDLE.
- **Reset mid-ownership:** outputs return to reset values at once; arbitration restarts on the first edge after `rst_n` rises.
- **Grant latency:** `req` sampled high at edge t gives `grant`, `owner`, `busy` and `disp_val` valid after edge t, i.e. one cycle.
- **Hold:** a contended owner keeps the grant for exactly `HOLD_CYCLES` cycles. The switch occurs on the edge where `hcnt`==`HOLD_CYCLES`-1.
- **Release latency:** owner `req` low at edge t gives the new `grant` (or 0) after edge t.
- **Output glitches:** `grant` is never multi-hot, and `disp_val` never shows a mixture of two requesters' values.

## Configuration
- **`DISPLAY_ARB_OWNER_DOT_EN` defined:**
  - While `busy`, `disp_dot` = owner's `dot` OR (4'b0001 << `owner`), so the dot under digit position `owner` marks the source.
  - In IDLE, `disp_dot`=0.
- **`DISPLAY_ARB_OWNER_DOT_EN` undefined:** `disp_dot` = owner's `dot` unchanged, with no extra logic.

## Test plan
Run with `HOLD_CYCLES`=4.
- **Reset, then single request:**
  - Stimulus: assert `rst_n`=0, release it, then `req`=4'b0100 with `val2`=16'hBEEF.
  - Required: one cycle later `grant`=4'b0100, `owner`=2, `busy`=1, `disp_val`=16'hBEEF.
  - Required: the grant is held indefinitely while uncontended.
- **Contention round-robin:**
  - Stimulus: `req`=4'b1111 held from reset.
  - Required: grants run 0,1,2,3,0…, each lasting exactly 4 cycles, with no idle gap.
- **Early release:**
  - Stimulus: owner 1 drops `req` at cycle 2 of hold while `req[3]` is high.
  - Required: `grant`=4'b1000 on the next edge and `hcnt` restarts.
- **Live tracking:**
  - Stimulus: owner 0 changes `val0` from 16'h1234 to 16'h5678.
  - Required: `disp_val`=16'h5678 one cycle later.
- **Async reset mid-hold:**
  - Stimulus: drive `rst_n` low between clock edges while `grant`=4'b0010.
  - Required: `grant`=0 and `disp_val`=`IDLE_VAL` immediately, with no clock needed.
  - Required: after release, `req`=4'b1111 grants requester 0 first.
- **Macro check:**
  - Stimulus: owner 2 with `dot2`=4'b0001.
  - Required: `disp_dot`=4'b0101 with `DISPLAY_ARB_OWNER_DOT_EN` defined, and 4'b0001 without it.

Source files
------------

// File: rtl/display_arbiter_if.sv
// Bundle between the four display requesters and the arbiter, plus the
// arbitrated value/dot pair handed on to the display driver.
interface display_arbiter_if;
    logic [3:0]  req;
    logic [15:0] val0;
    logic [15:0] val1;
    logic [15:0] val2;
    logic [15:0] val3;
    logic [3:0]  dot0;
    logic [3:0]  dot1;
    logic [3:0]  dot2;
    logic [3:0]  dot3;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] disp_val;
    logic [3:0]  disp_dot;

    modport master (
        output req, val0, val1, val2, val3, dot0, dot1, dot2, dot3,
        input  grant, owner, busy, disp_val, disp_dot
    );

    modport slave (
        input  req, val0, val1, val2, val3, dot0, dot1, dot2, dot3,
        output grant, owner, busy, disp_val, disp_dot
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter with minimum hold time for a shared 4-digit hex display.
// Define DISPLAY_ARB_OWNER_DOT_EN to light the dot under digit `owner` as a source marker.
module display_arbiter #(
    parameter logic [23:0] HOLD_CYCLES = 24'd10_000_000,
    parameter logic [15:0] IDLE_VAL    = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    display_arbiter_if.slave  bus
);

    // A hold of 0 behaves like 1: every cycle is already the expired state.
    localparam logic [23:0] HOLD_MAX = (HOLD_CYCLES == 24'd0) ? 24'd0 : HOLD_CYCLES - 24'd1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  last_reg, last_next;
    logic [23:0] hcnt_reg, hcnt_next;
    logic [3:0]  grant_reg, grant_next;
    logic [1:0]  owner_reg, owner_next;
    logic        busy_reg, busy_next;
    logic [15:0] disp_val_reg, disp_val_next;
    logic [3:0]  disp_dot_reg, disp_dot_next;

    logic [15:0] val_arr [4];
    logic [3:0]  dot_arr [4];
    logic [3:0]  other_req;

    assign val_arr[0] = bus.val0;
    assign val_arr[1] = bus.val1;
    assign val_arr[2] = bus.val2;
    assign val_arr[3] = bus.val3;
    assign dot_arr[0] = bus.dot0;
    assign dot_arr[1] = bus.dot1;
    assign dot_arr[2] = bus.dot2;
    assign dot_arr[3] = bus.dot3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_other
            assign other_req[gi] = bus.req[gi] && (owner_reg != 2'(gi));
        end
    endgenerate

    // First set bit of mask searching from (from+1) mod 4, wrapping back to from.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] from);
        logic [1:0] idx;
        rr_pick = from;
        for (int i = 4; i >= 1; i--) begin
            idx = from + 2'(i);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        logic       take;
        logic [3:0] pick_mask;
        logic [1:0] pick_idx;

        state_next = state_reg;
        last_next  = last_reg;
        hcnt_next  = hcnt_reg;
        owner_next = owner_reg;
        take       = 1'b0;
        pick_mask  = bus.req;

        case (state_reg)
            IDLE: begin
                take = |bus.req;
            end
            OWN: begin
                if (!bus.req[owner_reg]) begin
                    // A drop wins over expiry; the owner's bit is already clear in req.
                    take = |bus.req;
                    if (!(|bus.req)) state_next = IDLE;
                end else if ((hcnt_reg == HOLD_MAX) && (|other_req)) begin
                    take      = 1'b1;
                    pick_mask = other_req;
                end else if (hcnt_reg != HOLD_MAX) begin
                    hcnt_next = hcnt_reg + 24'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        pick_idx = rr_pick(pick_mask, last_reg);
        if (take) begin
            state_next = OWN;
            owner_next = pick_idx;
            last_next  = pick_idx;
            hcnt_next  = 24'd0;
        end

        grant_next    = 4'b0000;
        busy_next     = 1'b0;
        disp_val_next = IDLE_VAL;
        disp_dot_next = 4'b0000;
        if (state_next == OWN) begin
            grant_next    = 4'b0001 << owner_next;
            busy_next     = 1'b1;
            disp_val_next = val_arr[owner_next];
`ifdef DISPLAY_ARB_OWNER_DOT_EN
            disp_dot_next = dot_arr[owner_next] | (4'b0001 << owner_next);
`else
            disp_dot_next = dot_arr[owner_next];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_reg     <= 2'd3;
            hcnt_reg     <= 24'd0;
            grant_reg    <= 4'b0000;
            owner_reg    <= 2'd0;
            busy_reg     <= 1'b0;
            disp_val_reg <= IDLE_VAL;
            disp_dot_reg <= 4'b0000;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            hcnt_reg     <= hcnt_next;
            grant_reg    <= grant_next;
            owner_reg    <= owner_next;
            busy_reg     <= busy_next;
            disp_val_reg <= disp_val_next;
            disp_dot_reg <= disp_dot_next;
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.owner    = owner_reg;
    assign bus.busy     = busy_reg;
    assign bus.disp_val = disp_val_reg;
    assign bus.disp_dot = disp_dot_reg;

endmodule
